a2d_intf: RTL and testbench

- SPI master that round-robins the ADC128S over three channels: left load cell, right load cell, battery.
- Holds the latest 12-bit result for each channel in a register for the rider-detect/steer-enable and battery-low logic inside Segway.
- Sits directly between the Segway control core and the A2D_SS_n/A2D_SCLK/A2D_MOSI/A2D_MISO pins.
- Each conversion is started by a single-cycle `nxt` request from the core.

---
 rtl/segway_pkg.sv | 33 +++
 rtl/spi_mnrch.sv | 80 ++++++++
 rtl/a2d_intf.sv | 118 +++++++++++
 tb/tb_a2d_intf.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/segway_pkg.sv
// Purpose: shared constants and types for the Segway A2D interface and its SPI master.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package segway_pkg;

   // SPI word width used by the ADC128S framing
   localparam int SPI_W = 16;

   // ADC channel assignments
   localparam logic [2:0] LFT_CH  = 3'd0;
   localparam logic [2:0] RGHT_CH = 3'd4;
   localparam logic [2:0] BATT_CH = 3'd5;

   // Conversion state machine encoding
   typedef logic [2:0] state_t;
   localparam state_t IDLE = 3'd0;
   localparam state_t CMD  = 3'd1;
   localparam state_t GAP  = 3'd2;
   localparam state_t READ = 3'd3;
   localparam state_t UPD  = 3'd4;

   // Round-robin pointer values
   typedef logic [1:0] ptr_t;
   localparam ptr_t PTR_LFT  = 2'd0;
   localparam ptr_t PTR_RGHT = 2'd1;
   localparam ptr_t PTR_BATT = 2'd2;

   // ADC128S control word: channel address lives in bits [13:11]
   function automatic logic [SPI_W-1:0] cmd_word(input logic [2:0] ch);
      return {2'b00, ch, 11'h000};
   endfunction

endpackage

// File: rtl/spi_mnrch.sv
// Purpose: generic 16-bit SPI master (mode 3: SCLK idles high, drive on fall, sample on rise).
// Latency: SS_n low 17*SCLK_DIV clocks starting the cycle after wrt; done is high in the last SS_n-low cycle.
// Backpressure: none; wrt is ignored while a transaction is in flight.
// Ports: clk/rst; wrt + wt_data start a frame; done pulses at frame end, rd_data holds the received word;
//        SS_n/SCLK/MOSI/MISO are the SPI pins.
module spi_mnrch
   import segway_pkg::*;
#(
   parameter int SCLK_DIV = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wrt,
   input  logic [SPI_W-1:0] wt_data,
   output logic             done,
   output logic [SPI_W-1:0] rd_data,
   output logic             SS_n,
   output logic             SCLK,
   output logic             MOSI,
   input  logic             MISO
);

   localparam int LW = $clog2(SCLK_DIV);
   localparam int CW = $clog2(17 * SCLK_DIV);
   // Frame = SCLK_DIV/2 front porch + 16 periods + SCLK_DIV/2 back porch
   localparam logic [CW-1:0] LAST      = CW'(17 * SCLK_DIV - 1);
   localparam logic [CW-1:0] SHIFT_END = CW'(16 * SCLK_DIV);
   localparam logic [LW-1:0] HALF      = LW'(SCLK_DIV / 2);

   logic             active;
   logic [CW-1:0]    cnt;
   logic [CW-1:0]    cnt_nxt;
   logic [SPI_W-1:0] tx_sr;
   logic [SPI_W-1:0] rx_sr;
   logic             fall_nxt;
   logic             rise_nxt;

   // cnt counts clocks since SS_n fell; the phase within an SCLK period is cnt mod SCLK_DIV,
   // and SCLK is low for the upper half of each period inside the shift window.
   assign cnt_nxt  = cnt + CW'(1);
   assign fall_nxt = (cnt_nxt[LW-1:0] == HALF) && (cnt_nxt < SHIFT_END);
   assign rise_nxt = (cnt_nxt[LW-1:0] == '0) && (cnt_nxt <= SHIFT_END);

   assign done    = active && (cnt == LAST);
   assign SS_n    = ~active;
   assign rd_data = rx_sr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         active <= 1'b0;
         cnt    <= '0;
         tx_sr  <= '0;
         rx_sr  <= '0;
         SCLK   <= 1'b1;
         MOSI   <= 1'b0;
      end else if (!active) begin
         if (wrt) begin
            active <= 1'b1;
            cnt    <= '0;
            tx_sr  <= wt_data;
         end
      end else if (cnt == LAST) begin
         active <= 1'b0;
         SCLK   <= 1'b1;
         MOSI   <= 1'b0;
      end else begin
         cnt  <= cnt_nxt;
         SCLK <= ~(cnt_nxt[LW-1] && (cnt_nxt < SHIFT_END));
         if (fall_nxt) begin
            MOSI  <= tx_sr[SPI_W-1];
            tx_sr <= {tx_sr[SPI_W-2:0], 1'b0};
         end
         // MISO is only ever sampled inside the frame, so a floating line never reaches rx_sr
         if (rise_nxt) begin
            rx_sr <= {rx_sr[SPI_W-2:0], MISO};
         end
      end
   end

endmodule

// File: rtl/a2d_intf.sv
// Purpose: round-robin ADC128S reader (left load cell, right load cell, battery) holding latest 12-bit results.
// Latency: rdy pulses 2*(17*SCLK_DIV)+4 clocks after an accepted nxt.
// Backpressure: nxt is dropped (not queued) unless the machine is IDLE.
// Ports: clk/rst; nxt starts one conversion; lft_ld/rght_ld/batt results; rdy update strobe;
//        SS_n/SCLK/MOSI/MISO ADC pins.
module a2d_intf #(
   parameter int         SCLK_DIV = 32,
   parameter logic [2:0] LFT_CH   = segway_pkg::LFT_CH,
   parameter logic [2:0] RGHT_CH  = segway_pkg::RGHT_CH,
   parameter logic [2:0] BATT_CH  = segway_pkg::BATT_CH
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        nxt,
   output logic [11:0] lft_ld,
   output logic [11:0] rght_ld,
   output logic [11:0] batt,
   output logic        rdy,
   output logic        SS_n,
   output logic        SCLK,
   output logic        MOSI,
   input  logic        MISO
);

   import segway_pkg::*;

   state_t           state;
   ptr_t             ptr;
   logic             wrt;
   logic [SPI_W-1:0] wt_dat;
   logic             done;
   logic [SPI_W-1:0] rd_dat;
   logic [2:0]       ch_sel;
   logic             unused_rd_hi;

   // ADC128S returns four leading zeros above the 12-bit result
   assign unused_rd_hi = &{1'b0, rd_dat[SPI_W-1:12]};

   always_comb begin
      case (ptr)
         PTR_RGHT: ch_sel = RGHT_CH;
         PTR_BATT: ch_sel = BATT_CH;
         default:  ch_sel = LFT_CH;
      endcase
   end

   // wrt is registered, so each frame starts one clock after it is requested. In GAP the first
   // cycle raises wrt and the second hands it to the SPI master, keeping SS_n high exactly 2 clocks.
   // Results are written on the edge into UPD so the new value is visible alongside rdy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         ptr     <= PTR_LFT;
         wrt     <= 1'b0;
         wt_dat  <= '0;
         lft_ld  <= 12'h000;
         rght_ld <= 12'h000;
         batt    <= 12'h000;
         rdy     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (nxt) begin
                  wt_dat <= cmd_word(ch_sel);
                  wrt    <= 1'b1;
                  state  <= CMD;
               end
            end
            CMD: begin
               wrt <= 1'b0;
               if (done) state <= GAP;
            end
            GAP: begin
               if (!wrt) begin
                  wt_dat <= '0;
                  wrt    <= 1'b1;
               end else begin
                  wrt   <= 1'b0;
                  state <= READ;
               end
            end
            READ: begin
               if (done) begin
                  case (ptr)
                     PTR_RGHT: rght_ld <= rd_dat[11:0];
                     PTR_BATT: batt    <= rd_dat[11:0];
                     default:  lft_ld  <= rd_dat[11:0];
                  endcase
                  rdy   <= 1'b1;
                  state <= UPD;
               end
            end
            UPD: begin
               rdy   <= 1'b0;
               ptr   <= (ptr == PTR_BATT) ? PTR_LFT : ptr + 2'd1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   spi_mnrch #(
      .SCLK_DIV(SCLK_DIV)
   ) u_spi (
      .clk     (clk),
      .rst     (rst),
      .wrt     (wrt),
      .wt_data (wt_dat),
      .done    (done),
      .rd_data (rd_dat),
      .SS_n    (SS_n),
      .SCLK    (SCLK),
      .MOSI    (MOSI),
      .MISO    (MISO)
   );

endmodule

// File: tb/tb_a2d_intf.sv
// Purpose: self-checking bench for a2d_intf with a behavioural ADC128S and a channel/round-robin model.
// Latency: checks nxt-to-rdy distance of 34*SCLK_DIV+4 clocks.
// Backpressure: exercises nxt pulses issued while a conversion is busy.
module tb_a2d_intf;

   localparam int SCLK_DIV = 32;
   localparam int EXP_LAT  = 2 * (17 * SCLK_DIV) + 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        nxt;
   logic [11:0] lft_ld, rght_ld, batt;
   logic        rdy, SS_n, SCLK, MOSI;
   logic        MISO;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   a2d_intf #(.SCLK_DIV(SCLK_DIV)) dut (
      .clk     (clk),
      .rst     (rst),
      .nxt     (nxt),
      .lft_ld  (lft_ld),
      .rght_ld (rght_ld),
      .batt    (batt),
      .rdy     (rdy),
      .SS_n    (SS_n),
      .SCLK    (SCLK),
      .MOSI    (MOSI),
      .MISO    (MISO)
   );

   // ---------------- reference model ----------------
   logic [11:0] adc_val [3];   // analog input per logical channel (left, right, batt)
   logic [11:0] exp_reg [3];   // expected result registers
   int          exp_ptr;
   int          ch_num [3] = '{0, 4, 5};

   function automatic logic [11:0] val_of_ch(input logic [2:0] ch);
      if (ch == 3'd0) return adc_val[0];
      if (ch == 3'd4) return adc_val[1];
      if (ch == 3'd5) return adc_val[2];
      return 12'hFFF;
   endfunction

   // ---------------- ADC128S model + bus monitors ----------------
   int          cyc = 0;
   logic [15:0] adc_rx, adc_tx;
   int          adc_rises = 0;
   logic [2:0]  adc_ch = 3'd0;
   logic        miso_r = 1'b0;
   logic [15:0] mosi_q [$];
   int          last_fall = -1;
   int          per_min = 1000000, per_max = 0;
   int          rise_cyc = -1;
   int          gap_min = 1000000;

   always @(posedge clk) cyc++;

   assign MISO = (SS_n === 1'b0) ? miso_r : 1'bx;

   always @(negedge SS_n) begin
      adc_rises = 0;
      adc_tx    = {4'h0, val_of_ch(adc_ch)};
      miso_r    = adc_tx[15];
      last_fall = -1;
      if (rise_cyc >= 0 && (cyc - rise_cyc) < gap_min) gap_min = cyc - rise_cyc;
   end

   always @(posedge SS_n) begin
      rise_cyc = cyc;
      if (adc_rises == 16) begin
         mosi_q.push_back(adc_rx);
         adc_ch = adc_rx[13:11];
      end
   end

   always @(posedge SCLK) begin
      if (SS_n === 1'b0) begin
         adc_rx = {adc_rx[14:0], MOSI};
         adc_rises++;
      end
   end

   always @(negedge SCLK) begin
      if (SS_n === 1'b0) begin
         if (last_fall >= 0) begin
            if (cyc - last_fall < per_min) per_min = cyc - last_fall;
            if (cyc - last_fall > per_max) per_max = cyc - last_fall;
         end
         last_fall = cyc;
         if (adc_rises > 0 && adc_rises < 16) miso_r = adc_tx[15 - adc_rises];
      end
   end

   // ---------------- stimulus helper ----------------
   // Pulses nxt, optionally re-pulses it at clocks pa/pb, returns clocks until rdy (-1 on timeout).
   task automatic run_conv(input int pa, input int pb, output int lat);
      @(negedge clk);
      nxt = 1'b1;
      lat = -1;
      for (int k = 1; k <= 3000; k++) begin
         @(negedge clk);
         nxt = (k == pa) || (k == pb);
         if (rdy === 1'b1) begin
            lat = k;
            break;
         end
      end
      nxt = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      int rdy_cnt, low_cnt;
      rst = 1'b1;
      nxt = 1'b0;
      repeat (3) @(negedge clk);
      total++; if (SS_n !== 1'b1) $display("FAIL reset_ss_n: got %b want 1", SS_n); else passed++;
      total++; if (SCLK !== 1'b1) $display("FAIL reset_sclk: got %b want 1", SCLK); else passed++;
      total++; if (MOSI !== 1'b0) $display("FAIL reset_mosi: got %b want 0", MOSI); else passed++;
      total++; if (rdy !== 1'b0) $display("FAIL reset_rdy: got %b want 0", rdy); else passed++;
      total++; if (lft_ld !== 12'h000) $display("FAIL reset_lft: got %h want 000", lft_ld); else passed++;
      total++; if (rght_ld !== 12'h000) $display("FAIL reset_rght: got %h want 000", rght_ld); else passed++;
      total++; if (batt !== 12'h000) $display("FAIL reset_batt: got %h want 000", batt); else passed++;
      rst = 1'b0;
      rdy_cnt = 0;
      low_cnt = 0;
      repeat (200) begin
         @(negedge clk);
         if (rdy === 1'b1) rdy_cnt++;
         if (SS_n !== 1'b1) low_cnt++;
      end
      total++; if (rdy_cnt != 0) $display("FAIL idle_no_rdy: got %0d pulses want 0", rdy_cnt); else passed++;
      total++; if (low_cnt != 0) $display("FAIL idle_ss_n: got %0d low cycles want 0", low_cnt); else passed++;
      exp_ptr = 0;
      for (int i = 0; i < 3; i++) exp_reg[i] = 12'h000;
   endtask

   task automatic test_round_robin();
      int lat;
      logic [15:0] exp_cmd;
      adc_val[0] = 12'h205;
      adc_val[1] = 12'h1F3;
      adc_val[2] = 12'h0FF;
      for (int i = 0; i < 3; i++) begin
         exp_cmd = 16'(ch_num[exp_ptr] * 2048);
         mosi_q.delete();
         run_conv(-1, -1, lat);
         exp_reg[exp_ptr] = adc_val[exp_ptr];
         exp_ptr = (exp_ptr + 1) % 3;
         total++; if (lat != EXP_LAT) $display("FAIL rr_latency[%0d]: got %0d want %0d", i, lat, EXP_LAT); else passed++;
         total++; if (lft_ld !== exp_reg[0]) $display("FAIL rr_lft[%0d]: got %h want %h", i, lft_ld, exp_reg[0]); else passed++;
         total++; if (rght_ld !== exp_reg[1]) $display("FAIL rr_rght[%0d]: got %h want %h", i, rght_ld, exp_reg[1]); else passed++;
         total++; if (batt !== exp_reg[2]) $display("FAIL rr_batt[%0d]: got %h want %h", i, batt, exp_reg[2]); else passed++;
         @(negedge clk);
         total++; if (rdy !== 1'b0) $display("FAIL rr_rdy_width[%0d]: got %b want 0", i, rdy); else passed++;
         total++;
         if (mosi_q.size() != 2) $display("FAIL rr_frames[%0d]: got %0d frames want 2", i, mosi_q.size());
         else if (mosi_q[0] !== exp_cmd || mosi_q[1] !== 16'h0000)
            $display("FAIL rr_mosi[%0d]: got %h/%h want %h/0000", i, mosi_q[0], mosi_q[1], exp_cmd);
         else passed++;
      end
   endtask

   task automatic test_spi_timing();
      total++; if (per_min != SCLK_DIV || per_max != SCLK_DIV)
         $display("FAIL sclk_period: got %0d..%0d want %0d", per_min, per_max, SCLK_DIV); else passed++;
      total++; if (gap_min < 2) $display("FAIL ss_n_gap: got %0d want >=2", gap_min); else passed++;
   endtask

   task automatic test_wrap();
      int lat;
      adc_val[0] = 12'hABC;
      run_conv(-1, -1, lat);
      exp_reg[exp_ptr] = adc_val[exp_ptr];
      exp_ptr = (exp_ptr + 1) % 3;
      total++; if (lat != EXP_LAT) $display("FAIL wrap_latency: got %0d want %0d", lat, EXP_LAT); else passed++;
      total++; if (lft_ld !== 12'hABC) $display("FAIL wrap_lft: got %h want abc", lft_ld); else passed++;
      total++; if (rght_ld !== 12'h1F3) $display("FAIL wrap_rght: got %h want 1f3", rght_ld); else passed++;
      total++; if (batt !== 12'h0FF) $display("FAIL wrap_batt: got %h want 0ff", batt); else passed++;
   endtask

   task automatic test_busy();
      int lat, extra, pa, pb;
      for (int i = 0; i < 4; i++) begin
         adc_val[exp_ptr] = 12'($urandom);
         if (i == 0) begin
            pa = 100;
            pb = 600;
         end else begin
            pa = $urandom_range(1, EXP_LAT - 1);
            pb = $urandom_range(1, EXP_LAT - 1);
         end
         run_conv(pa, pb, lat);
         exp_reg[exp_ptr] = adc_val[exp_ptr];
         exp_ptr = (exp_ptr + 1) % 3;
         total++; if (lat != EXP_LAT) $display("FAIL busy_latency[%0d]: got %0d want %0d", i, lat, EXP_LAT); else passed++;
         total++; if (lft_ld !== exp_reg[0] || rght_ld !== exp_reg[1] || batt !== exp_reg[2])
            $display("FAIL busy_regs[%0d]: got %h %h %h want %h %h %h", i, lft_ld, rght_ld, batt,
                     exp_reg[0], exp_reg[1], exp_reg[2]); else passed++;
         extra = 0;
         repeat (1200) begin
            @(negedge clk);
            if (rdy === 1'b1) extra++;
         end
         total++; if (extra != 0) $display("FAIL busy_extra_rdy[%0d]: got %0d want 0", i, extra); else passed++;
      end
   endtask

   task automatic test_reset_mid();
      int lat;
      @(negedge clk);
      nxt = 1'b1;
      @(negedge clk);
      nxt = 1'b0;
      repeat (799) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      total++; if (SS_n !== 1'b1) $display("FAIL midrst_ss_n: got %b want 1", SS_n); else passed++;
      total++; if (SCLK !== 1'b1 || MOSI !== 1'b0) $display("FAIL midrst_pins: got %b%b want 10", SCLK, MOSI); else passed++;
      total++; if (lft_ld !== 12'h000 || rght_ld !== 12'h000 || batt !== 12'h000)
         $display("FAIL midrst_regs: got %h %h %h want 000", lft_ld, rght_ld, batt); else passed++;
      total++; if (rdy !== 1'b0) $display("FAIL midrst_rdy: got %b want 0", rdy); else passed++;
      @(negedge clk);
      rst = 1'b0;
      exp_ptr = 0;
      for (int i = 0; i < 3; i++) exp_reg[i] = 12'h000;
      repeat (5) @(negedge clk);
      mosi_q.delete();
      adc_val[0] = 12'($urandom);
      run_conv(-1, -1, lat);
      exp_reg[exp_ptr] = adc_val[exp_ptr];
      exp_ptr = (exp_ptr + 1) % 3;
      total++; if (lat != EXP_LAT) $display("FAIL postrst_latency: got %0d want %0d", lat, EXP_LAT); else passed++;
      total++; if (lft_ld !== exp_reg[0] || rght_ld !== 12'h000 || batt !== 12'h000)
         $display("FAIL postrst_regs: got %h %h %h want %h 000 000", lft_ld, rght_ld, batt, exp_reg[0]); else passed++;
      total++;
      if (mosi_q.size() < 1) $display("FAIL postrst_cmd: got no frame want 0000");
      else if (mosi_q[0] !== 16'h0000) $display("FAIL postrst_cmd: got %h want 0000", mosi_q[0]);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_spi_timing();
      test_wrap();
      test_busy();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
